// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch unit: one outstanding word read, instruction register, PC advance on consume.
// Optional build macro IFU_ILLEGAL_CHECK_EN traps fetched words whose low two bits are not 2'b11.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [6:0]  o_op,
    output logic [2:0]  o_funct3,
    output logic        o_funct7b5,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcplus4,
    input  logic        i_pcsrc,
    input  logic [31:0] i_pctarget,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        req_r;
    logic        valid_r;
    logic        trap_r;
    logic [1:0]  cause_r;
    logic [31:0] pcplus4_s;
    logic [31:0] next_pc_s;
    logic        illegal_s;

`ifdef IFU_ILLEGAL_CHECK_EN
    assign illegal_s = (i_imem_rdata[1:0] != 2'b11);
`else
    assign illegal_s = 1'b0;
`endif

    assign pcplus4_s = pc_r + 32'd4;
    assign next_pc_s = i_pcsrc ? i_pctarget : pcplus4_s;

    // Fetch FSM; the handshake outputs are registered alongside the state so they never glitch.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0013;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
            trap_r  <= 1'b0;
            cause_r <= 2'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (i_imem_gnt) begin
                        state_r <= WAIT;
                        req_r   <= 1'b0;
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        instr_r <= i_imem_rdata;
                        if (illegal_s) begin
                            state_r <= TRAP;
                            trap_r  <= 1'b1;
                            cause_r <= 2'd2;
                        end else begin
                            state_r <= HOLD;
                            valid_r <= 1'b1;
                        end
                    end else begin
                        req_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        valid_r <= 1'b0;
                        // A misaligned successor is reported without moving the PC off the faulting instruction.
                        if (next_pc_s[1:0] != 2'b00) begin
                            state_r <= TRAP;
                            trap_r  <= 1'b1;
                            cause_r <= 2'd1;
                        end else begin
                            state_r <= FETCH;
                            pc_r    <= next_pc_s;
                            req_r   <= 1'b1;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                TRAP: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    trap_r  <= 1'b1;
                end
                default: begin
                    state_r <= TRAP;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    trap_r  <= 1'b1;
                end
            endcase
        end
    end

    assign o_imem_req   = req_r;
    assign o_imem_addr  = pc_r;
    assign o_valid      = valid_r;
    assign o_instr      = instr_r;
    assign o_op         = instr_r[6:0];
    assign o_funct3     = instr_r[14:12];
    assign o_funct7b5   = instr_r[30];
    assign o_pc         = pc_r;
    assign o_pcplus4    = pcplus4_s;
    assign o_trap       = trap_r;
    assign o_trap_cause = cause_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus randomized fetch/consume traffic
// checked against a PC-sequence reference model and an address-derived memory image.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        trap;
    logic [1:0]  trap_cause;

    int          vec_count;
    int          miscompares;
    logic [31:0] last_instr;
    logic [31:0] pc_model;

    instr_fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_instr       (instr),
        .o_op          (op),
        .o_funct3      (funct3),
        .o_funct7b5    (funct7b5),
        .o_pc          (pc),
        .o_pcplus4     (pcplus4),
        .i_pcsrc       (pcsrc),
        .i_pctarget    (pctarget),
        .o_trap        (trap),
        .o_trap_cause  (trap_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ 30'h2A5A_5A5A, 2'b11};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; ready = 1'b0;
        step();
        step();
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_cause", {30'd0, trap_cause}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0000_0000);
        chk("rel_valid", {31'd0, valid}, 32'd0);
        last_instr = 32'h0000_0013;
    endtask

    // Drive one memory transaction with gw grant wait states and rw response wait states.
    task automatic fetch(input int gw, input int rw, input logic [31:0] data, input logic [31:0] exp_pc);
        for (int i = 0; i < gw; i++) begin
            chk("fetch_req_held", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr_held", imem_addr, exp_pc);
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = 32'hDEAD_BEEF;
            ready       = 1'($urandom_range(0, 1));
            pcsrc       = 1'($urandom_range(0, 1));
            pctarget    = $urandom();
            step();
            chk("fetch_spurious_instr", instr, last_instr);
        end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        imem_gnt = 1'b1; imem_rvalid = 1'b0;
        step();
        imem_gnt = 1'b0;
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        chk("wait_valid", {31'd0, valid}, 32'd0);
        for (int i = 0; i < rw; i++) begin
            ready = 1'($urandom_range(0, 1));
            step();
            chk("wait_req_low", {31'd0, imem_req}, 32'd0);
            chk("wait_valid_low", {31'd0, valid}, 32'd0);
        end
        imem_rvalid = 1'b1; imem_rdata = data; ready = 1'($urandom_range(0, 1));
        step();
        imem_rvalid = 1'b0; ready = 1'b0;
        pcsrc = 1'($urandom_range(0, 1)); pctarget = $urandom();
        last_instr = data;
    endtask

    task automatic check_hold(input logic [31:0] exp_pc, input logic [31:0] data);
        chk("hold_valid", {31'd0, valid}, 32'd1);
        chk("hold_instr", instr, data);
        chk("hold_op", {25'd0, op}, {25'd0, data[6:0]});
        chk("hold_funct3", {29'd0, funct3}, {29'd0, data[14:12]});
        chk("hold_funct7b5", {31'd0, funct7b5}, {31'd0, data[30]});
        chk("hold_pc", pc, exp_pc);
        chk("hold_pcplus4", pcplus4, exp_pc + 32'd4);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_trap", {31'd0, trap}, 32'd0);
    endtask

    task automatic stall(input int n, input logic [31:0] exp_pc, input logic [31:0] data);
        for (int i = 0; i < n; i++) begin
            ready = 1'b0; pcsrc = 1'($urandom_range(0, 1)); pctarget = $urandom();
            step();
            chk("stall_pc", pc, exp_pc);
            chk("stall_instr", instr, data);
            chk("stall_valid", {31'd0, valid}, 32'd1);
        end
    endtask

    task automatic consume(input logic src, input logic [31:0] tgt);
        pcsrc = src; pctarget = tgt; ready = 1'b1;
        step();
        ready = 1'b0; pcsrc = 1'($urandom_range(0, 1)); pctarget = $urandom();
    endtask

    initial begin
        vec_count = 0; miscompares = 0;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        ready = 1'b0; pcsrc = 1'b0; pctarget = 32'd0;
        last_instr = 32'h0000_0013; pc_model = 32'd0;

        apply_reset();

        // Zero-wait fetch of addi at address 0, then sequential advance.
        fetch(0, 0, 32'h0050_0093, 32'h0);
        check_hold(32'h0, 32'h0050_0093);
        chk("t1_op", {25'd0, op}, 32'h13);
        chk("t1_funct3", {29'd0, funct3}, 32'd0);
        consume(1'b0, 32'h0);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_next_req", {31'd0, imem_req}, 32'd1);
        chk("t1_next_valid", {31'd0, valid}, 32'd0);

        // Taken branches to 0x10 and 0x40.
        fetch(0, 1, mem_word(32'h4), 32'h4);
        check_hold(32'h4, mem_word(32'h4));
        consume(1'b1, 32'h10);
        chk("br_addr_10", imem_addr, 32'h10);
        fetch(1, 0, mem_word(32'h10), 32'h10);
        check_hold(32'h10, mem_word(32'h10));
        consume(1'b1, 32'h40);
        chk("br_addr_40", imem_addr, 32'h40);
        chk("br_pcplus4_44", pcplus4, 32'h44);

        // Grant withheld three cycles with spurious responses, then a held instruction.
        fetch(3, 0, mem_word(32'h40), 32'h40);
        check_hold(32'h40, mem_word(32'h40));
        stall(3, 32'h40, mem_word(32'h40));

        // PC wrap from the top of the address space.
        consume(1'b1, 32'hFFFF_FFFC);
        fetch(0, 0, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC);
        check_hold(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        chk("wrap_pcplus4", pcplus4, 32'h0);
        consume(1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_trap", {31'd0, trap}, 32'd0);
        pc_model = 32'h0;

        // Randomized traffic against the PC-sequence model.
        for (int it = 0; it < 40; it++) begin
            logic        src;
            logic [31:0] tgt;
            fetch($urandom_range(0, 3), $urandom_range(0, 3), mem_word(pc_model), pc_model);
            check_hold(pc_model, mem_word(pc_model));
            stall($urandom_range(0, 2), pc_model, mem_word(pc_model));
            src = 1'($urandom_range(0, 1));
            tgt = $urandom() & 32'hFFFF_FFFC;
            consume(src, tgt);
            pc_model = src ? tgt : pc_model + 32'd4;
            chk("rnd_next_addr", imem_addr, pc_model);
            chk("rnd_next_req", {31'd0, imem_req}, 32'd1);
        end

        // Misaligned target traps and stays trapped until reset.
        fetch(0, 0, mem_word(pc_model), pc_model);
        check_hold(pc_model, mem_word(pc_model));
        consume(1'b1, 32'h0000_0102);
        chk("trap_flag", {31'd0, trap}, 32'd1);
        chk("trap_cause1", {30'd0, trap_cause}, 32'd1);
        chk("trap_pc", pc, pc_model);
        chk("trap_valid", {31'd0, valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
            ready = 1'b1; pcsrc = 1'b0;
            step();
            chk("trap_no_req", {31'd0, imem_req}, 32'd0);
            chk("trap_sticky", {31'd0, trap}, 32'd1);
            chk("trap_pc_hold", pc, pc_model);
        end
        apply_reset();

        // Reset during WAIT, then a stale response right after release.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("rw_in_wait", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("stale_instr", instr, 32'h0000_0013);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        chk("stale_addr", imem_addr, 32'h0);
        chk("stale_valid", {31'd0, valid}, 32'd0);

        // All-zero word: illegal in the checking build, ordinary otherwise.
        fetch(0, 0, 32'h0000_0000, 32'h0);
`ifdef IFU_ILLEGAL_CHECK_EN
        chk("ill_trap", {31'd0, trap}, 32'd1);
        chk("ill_cause", {30'd0, trap_cause}, 32'd2);
        chk("ill_instr", instr, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ill_valid", {31'd0, valid}, 32'd0);
        end
`else
        check_hold(32'h0, 32'h0000_0000);
        chk("ill_cause_none", {30'd0, trap_cause}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
